// File: rtl/sample_decimate.sv
// Streaming integer-rate downsampler: forwards the sample at phase G_KEEP_PHASE
// of every G_DOWNSAMPLE_RATE accepted inputs into a one-entry registered output.
module sample_decimate #(
  parameter int G_DWIDTH          = 24,
  parameter int G_DOWNSAMPLE_RATE = 4,
  parameter int G_KEEP_PHASE      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [G_DWIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [G_DWIDTH-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam logic [15:0] LAST_PHASE = 16'(G_DOWNSAMPLE_RATE - 1);
  localparam logic [15:0] KEEP_PHASE = 16'(G_KEEP_PHASE);

  typedef enum logic [0:0] {
    SM_INIT = 1'b0,
    SM_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] phase;
  logic [15:0] phase_next;
  logic        keep_slot;
  logic        accept;

  assign keep_slot = (phase == KEEP_PHASE);
  assign accept    = din_valid && din_ready;

  // Next state and input acceptance; only the kept slot waits on the output register.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    case (state)
      SM_INIT: begin
        din_ready  = 1'b0;
        state_next = SM_RUN;
      end
      SM_RUN: begin
        if (keep_slot) begin
          din_ready = !dout_valid || dout_ready;
        end else begin
          din_ready = 1'b1;
        end
        state_next = SM_RUN;
      end
      default: begin
        din_ready  = 1'b0;
        state_next = SM_INIT;
      end
    endcase
  end

  // Phase advance on every accepted input, wrapping at R-1.
  always_comb begin
    phase_next = phase;
    if (!accept) begin
      phase_next = phase;
    end else if (phase >= LAST_PHASE) begin
      phase_next = 16'd0;
    end else begin
      phase_next = phase + 16'd1;
    end
  end

  // State, phase and output register; a push wins over a simultaneous pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SM_INIT;
      phase      <= 16'd0;
      dout       <= {G_DWIDTH{1'b0}};
      dout_valid <= 1'b0;
    end else if (!enable) begin
      state      <= SM_INIT;
      phase      <= 16'd0;
      dout       <= {G_DWIDTH{1'b0}};
      dout_valid <= 1'b0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      if (accept && keep_slot) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_decimate.sv
// Scoreboard bench for sample_decimate: three instances (R=4/K=0, R=4/K=3, R=1/K=0)
// driven with directed vectors; a negedge monitor pops expected outputs on each handshake.
module tb_sample_decimate;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [23:0] din_a  [3];
  logic        dv     [3];
  logic        dr     [3];
  logic [23:0] dout_a [3];
  logic        dov    [3];
  logic        dordy  [3];
  logic        rand_ready;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] q2[$];

  int checks;
  int errors;

  sample_decimate #(.G_DWIDTH(24), .G_DOWNSAMPLE_RATE(4), .G_KEEP_PHASE(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .din(din_a[0]), .din_valid(dv[0]), .din_ready(dr[0]),
    .dout(dout_a[0]), .dout_valid(dov[0]), .dout_ready(dordy[0])
  );

  sample_decimate #(.G_DWIDTH(24), .G_DOWNSAMPLE_RATE(4), .G_KEEP_PHASE(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .din(din_a[1]), .din_valid(dv[1]), .din_ready(dr[1]),
    .dout(dout_a[1]), .dout_valid(dov[1]), .dout_ready(dordy[1])
  );

  sample_decimate #(.G_DWIDTH(24), .G_DOWNSAMPLE_RATE(1), .G_KEEP_PHASE(0)) dut_c (
    .clk(clk), .reset(reset), .enable(enable),
    .din(din_a[2]), .din_valid(dv[2]), .din_ready(dr[2]),
    .dout(dout_a[2]), .dout_valid(dov[2]), .dout_ready(dordy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic pop_check(input int d, input logic [23:0] got);
    logic [23:0] exp;
    int          sz;
    case (d)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_output dut%0d got %0d expected none at %0t", d, got, $time);
    end else begin
      case (d)
        0: exp = q0.pop_front();
        1: exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      if (got !== exp) begin
        errors++;
        $display("FAIL output_data dut%0d got %0d expected %0d at %0t", d, got, exp, $time);
      end
    end
  endtask

  // Monitor: the output transfer happens at the next posedge when valid && ready here.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dov[k] === 1'b1 && dordy[k] === 1'b1) pop_check(k, dout_a[k]);
    end
  end

  // Random downstream stalls for the pass-through instance.
  always @(posedge clk) begin
    #1;
    if (rand_ready) dordy[2] = ($urandom_range(0, 1) == 1);
  end

  // Present one sample and hold it until a handshake; returns the stall count.
  task automatic send(input int d, input logic [23:0] v, output int stalls);
    logic acc;
    stalls = 0;
    din_a[d] = v;
    dv[d]    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = dr[d];
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
    end
    if (stalls >= 200) check_bit("handshake_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Continuous stream 1..12 into the R=4/K=0 instance.
  task automatic run_stream();
    int st;
    int total;
    total = 0;
    dordy[0] = 1'b1;
    q0.push_back(24'd1);
    q0.push_back(24'd5);
    q0.push_back(24'd9);
    for (int v = 1; v <= 12; v++) begin
      send(0, 24'(v), st);
      total += st;
      if (v % 4 == 1) begin
        check_bit("s1_latency_valid", dov[0], 1'b1);
        check_word("s1_latency_data", dout_a[0], 24'(v));
      end
    end
    dv[0] = 1'b0;
    check_word("s1_no_stalls", 24'(total), 24'd0);
    idle(3);
    check_word("s1_queue_drained", 24'(q0.size()), 24'd0);
  endtask

  task automatic restart();
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(1);
  endtask

  initial begin
    int st;
    logic [23:0] v;
    checks = 0;
    errors = 0;
    rand_ready = 1'b0;
    reset  = 1'b1;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din_a[k] = 24'd0;
      dv[k]    = 1'b0;
      dordy[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_bit("reset_din_ready", dr[k], 1'b0);
      check_bit("reset_dout_valid", dov[k], 1'b0);
      check_word("reset_dout", dout_a[k], 24'd0);
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check_bit("init_din_ready_low", dr[0], 1'b0);
    @(negedge clk);
    check_bit("run_din_ready_high", dr[0], 1'b1);
    @(posedge clk);
    #1;

    // 1: continuous stream, keep phase 0
    run_stream();

    // 2: keep phase 3
    q1.push_back(24'd4);
    q1.push_back(24'd8);
    q1.push_back(24'd12);
    for (int i = 1; i <= 12; i++) begin
      send(1, 24'(i), st);
      if (i % 4 == 0) check_word("s2_kept_data", dout_a[1], 24'(i));
    end
    dv[1] = 1'b0;
    idle(3);
    check_word("s2_queue_drained", 24'(q1.size()), 24'd0);

    // 3: backpressure with simultaneous pop and push
    dordy[0] = 1'b0;
    q0.push_back(24'd1);
    q0.push_back(24'd5);
    for (int i = 1; i <= 4; i++) begin
      send(0, 24'(i), st);
      check_word("s3_accept_no_stall", 24'(st), 24'd0);
      check_word("s3_dout_held", dout_a[0], 24'd1);
    end
    din_a[0] = 24'd5;
    dv[0]    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_bit("s3_din_ready_blocked", dr[0], 1'b0);
      check_word("s3_dout_stable", dout_a[0], 24'd1);
      check_bit("s3_dout_valid_stable", dov[0], 1'b1);
    end
    @(posedge clk);
    #1;
    dordy[0] = 1'b1;
    @(negedge clk);
    check_bit("s3_din_ready_on_pop", dr[0], 1'b1);
    @(posedge clk);
    #1;
    dordy[0] = 1'b0;
    dv[0]    = 1'b0;
    @(negedge clk);
    check_bit("s3_valid_after_pop_push", dov[0], 1'b1);
    check_word("s3_new_data", dout_a[0], 24'd5);
    @(posedge clk);
    #1;
    dordy[0] = 1'b1;
    idle(3);
    check_word("s3_queue_drained", 24'(q0.size()), 24'd0);

    // 4: pass-through with random stalls on both sides
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      dv[2] = 1'b0;
      idle($urandom_range(0, 1));
      v = 24'(16 + i * 37);
      q2.push_back(v);
      send(2, v, st);
    end
    dv[2] = 1'b0;
    rand_ready = 1'b0;
    idle(1);
    dordy[2] = 1'b1;
    idle(4);
    check_word("s4_queue_drained", 24'(q2.size()), 24'd0);

    // 5: enable dropped with output 5 pending
    restart();
    dordy[0] = 1'b1;
    q0.push_back(24'd1);
    for (int i = 1; i <= 4; i++) send(0, 24'(i), st);
    dordy[0] = 1'b0;
    send(0, 24'd5, st);
    check_word("s5_pending_data", dout_a[0], 24'd5);
    send(0, 24'd6, st);
    dv[0]  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_bit("s5_cleared_valid", dov[0], 1'b0);
    check_word("s5_cleared_dout", dout_a[0], 24'd0);
    check_bit("s5_cleared_din_ready", dr[0], 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check_bit("s5_init_din_ready", dr[0], 1'b0);
    @(posedge clk);
    #1;
    dordy[0] = 1'b1;
    q0.push_back(24'd7);
    for (int i = 7; i <= 10; i++) begin
      send(0, 24'(i), st);
      if (i == 7) check_word("s5_first_after_enable", dout_a[0], 24'd7);
    end
    dv[0] = 1'b0;
    idle(3);
    check_word("s5_queue_drained", 24'(q0.size()), 24'd0);

    // 6: asynchronous reset between edges
    dordy[0] = 1'b0;
    send(0, 24'd1, st);
    dv[0] = 1'b0;
    check_bit("s6_pre_reset_valid", dov[0], 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_bit("s6_async_valid", dov[0], 1'b0);
    check_word("s6_async_dout", dout_a[0], 24'd0);
    check_bit("s6_async_din_ready", dr[0], 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_bit("s6_init_din_ready", dr[0], 1'b0);
    @(posedge clk);
    #1;
    run_stream();

    check_word("final_q0_empty", 24'(q0.size()), 24'd0);
    check_word("final_q1_empty", 24'(q1.size()), 24'd0);
    check_word("final_q2_empty", 24'(q2.size()), 24'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_decimate.md
# sample_decimate

Streaming integer-rate downsampler for the DSP datapath, the inverse of the upsampling zero-insertion stage. It accepts one sample per input handshake and forwards only the sample at a fixed phase of every `G_DOWNSAMPLE_RATE` inputs. All other samples are consumed and discarded. It sits after the anti-alias FIR on the decimation path and drives a one-entry registered output with valid/ready flow control.

## Interface
- `G_DWIDTH`, default 24: sample width in bits.
- `G_DOWNSAMPLE_RATE`, default 4: decimation factor R. Legal range 1..65535.
- `G_KEEP_PHASE`, default 0: index within each group of R inputs that is forwarded. Legal range 0..R-1.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  synchronous run enable. Low holds the block in its idle/cleared state.
- `din`  in  `G_DWIDTH`  input sample.
- `din_valid`  in  1  input sample valid.
- `din_ready`  out  1  block can accept `din` this cycle.
- `dout`  out  `G_DWIDTH`  output sample (registered).
- `dout_valid`  out  1  output holds a kept sample (registered).
- `dout_ready`  in  1  downstream accepts `dout`.

## Operation
State machine:
- **SM_INIT**
  - `din_ready` = 0.
  - Unconditionally moves to SM_RUN on the next clock.
- **SM_RUN**
  - Normal operation. No exit except reset or `enable` = 0.

Phase counter:
- 16-bit unsigned `phase`.
- Increments by 1 on every accepted input (`din_valid && din_ready`).
- Wraps from R-1 to 0. With R = 1 it stays at 0.
- Unchanged on cycles with no accepted input.

Input acceptance, combinational, in SM_RUN:
- When `phase` != `G_KEEP_PHASE`: `din_ready` = 1. Dropped samples never wait on the output.
- When `phase` == `G_KEEP_PHASE`: `din_ready` = `!dout_valid || dout_ready`.

Output register, one entry:
- Accepted input with `phase` == `G_KEEP_PHASE`: `dout` <= `din`, `dout_valid` <= 1. This takes priority over the clear below, so simultaneous pop and push leaves `dout_valid` = 1 with new data.
- Otherwise, if `dout_valid && dout_ready`: `dout_valid` <= 0. `dout` keeps its last value.
- Dropped samples never modify `dout`.

Protocol:
- `dout` and `dout_valid` are stable while `dout_valid` = 1 and `dout_ready` = 0.
- No sample is lost or duplicated.

Clearing:
- `reset` = 1 (asynchronous) or `enable` = 0 (synchronous) forces:
  - state = SM_INIT
  - `phase` = 0
  - `dout` = 0
  - `dout_valid` = 0
- A pending output sample is discarded.
- After re-enable, the first accepted input is phase 0.

## Timing
- Reset values: `din_ready` = 0, `dout` = 0, `dout_valid` = 0.
- First cycle `din_ready` can be 1: the second rising edge after `reset` deasserts with `enable` = 1 (one cycle in SM_INIT).
- Latency: a kept sample accepted on edge N is presented on `dout` with `dout_valid` = 1 immediately after edge N, i.e. one cycle.
- Throughput: one input per cycle. With `dout_ready` held at 1, one output every R input handshakes. No bubbles.
- Backpressure: with the output full and `dout_ready` = 0:
  - Inputs continue to be accepted until `phase` reaches `G_KEEP_PHASE`.
  - `din_ready` then drops to 0 until the output drains.
- Combinational path: `dout_ready` -> `din_ready`. There is no combinational path from `din` to `dout`.
- `enable` deasserted on an edge clears state on that edge. `din_ready` is 0 in the following cycle.

## Test plan
1. **Continuous stream, default phase.** R = 4, `G_KEEP_PHASE` = 0. Drive `din` 1..12 back-to-back, `dout_ready` = 1. Expect `dout` = 1, 5, 9, each valid the cycle after its input handshake. `din_ready` stays 1 throughout.
2. **Non-zero keep phase.** R = 4, `G_KEEP_PHASE` = 3. Drive `din` 1..12. Expect `dout` = 4, 8, 12.
3. **Backpressure.** R = 4, `G_KEEP_PHASE` = 0. Hold `dout_ready` = 0 after the first output (1).
   - Expect inputs 2, 3, 4 accepted, then `din_ready` = 0 with 5 waiting and `dout` held at 1.
   - Raise `dout_ready` for 1 cycle: 1 pops, 5 is accepted in the same cycle, and `dout` = 5.
4. **Pass-through.** R = 1, random stalls on both sides (valid/ready each ~50%). Expect the output sequence to equal the input sequence exactly.
5. **Enable mid-stream.** R = 4. Drop `enable` after inputs 1..6 with output 5 pending. Expect `dout_valid` = 0 and 5 discarded. After re-enable and the one-cycle SM_INIT, inputs 7..10 produce `dout` = 7.
6. **Asynchronous reset.** Assert `reset` between clock edges mid-stream. Expect `dout_valid`, `dout`, and `din_ready` to go to 0 immediately without a clock edge. After release, behaviour matches scenario 1.
